// File: rtl/sy_fifo_common_pkg.sv
// sy_fifo_common: shared defaults and reader FSM state type for the sync FIFO family
package sy_fifo_common;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, HALT} rd_state_e;
endpackage

// File: rtl/sy_skid_buf2.sv
// sy_skid_buf2: 2-entry in-order buffer with push/pop and occupancy count
module sy_skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      occ    <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sy_fifo_rd_stream.sv
// sy_fifo_rd_stream: drains a sync FIFO read port into a valid/ready stream via a 2-entry skid buffer
// Optional beat counter output beat_cnt_o when SY_FIFO_RD_STREAM_CNT_EN is defined.
module sy_fifo_rd_stream
  import sy_fifo_common::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SKID_DEP = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_error_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             err_o
`ifdef SY_FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]      beat_cnt_o
`endif
);
  generate
    if (SKID_DEP != 2) begin : g_bad_dep
      $error("sy_fifo_rd_stream: SKID_DEP must be 2");
    end
  endgenerate
  rd_state_e  state;
  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [1:0] occ_eff;
  assign pop          = m_valid_o && m_ready_i;
  assign m_valid_o    = occ != 2'd0;
  // a beat popped this cycle frees its slot for a read issued this same cycle
  assign occ_eff      = occ - {1'b0, pop};
  assign fifo_rd_en_o = (state == RUN) && !fifo_empty_i && ((occ_eff + {1'b0, inflight}) < 2'd2);
  sy_skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (inflight),
    .wdata (fifo_rdata_i),
    .pop   (pop),
    .rdata (m_data_o),
    .occ   (occ)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      inflight <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      inflight <= fifo_rd_en_o;
      state    <= state == IDLE ? (en_i ? RUN : IDLE)
                : state == RUN  ? (fifo_error_i ? HALT : en_i ? RUN : IDLE)
                : HALT;
      err_o    <= err_o | (state == RUN && fifo_error_i);
    end
  end
`ifdef SY_FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) beat_cnt_o <= 32'd0;
    else if (pop) beat_cnt_o <= beat_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_sy_fifo_rd_stream.sv
// tb_sy_fifo_rd_stream: table-driven stream scenarios plus error and mid-operation reset sequences
module tb_sy_fifo_rd_stream;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         en_i = 1'b0;
  logic         fifo_rd_en_o;
  logic [W-1:0] fifo_rdata_i = '0;
  logic         fifo_empty_i = 1'b1;
  logic         fifo_error_i = 1'b0;
  logic         m_valid_o;
  logic [W-1:0] m_data_o;
  logic         m_ready_i = 1'b1;
  logic         err_o;
`ifdef SY_FIFO_RD_STREAM_CNT_EN
  logic [31:0]  beat_cnt_o;
`endif
  sy_fifo_rd_stream #(.WIDTH(W), .SKID_DEP(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_error_i (fifo_error_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_ready_i    (m_ready_i),
    .err_o        (err_o)
`ifdef SY_FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt_o   (beat_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int           n;
    logic [W-1:0] base;
    int           stall_at;
    int           stall_len;
    int           rd_span;
  } vec_t;
  vec_t         vt[4];
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, beats = 0, rden_cnt = 0;
  int fr = -1, lr = -1, fv = -1, lv = -1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // behavioural FIFO: 1-cycle read latency, registered empty flag
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en_o && fq.size() != 0) fifo_rdata_i <= fq.pop_front();
    fifo_empty_i <= (fq.size() == 0);
  end
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (fifo_rd_en_o) begin
      chk("rd_not_empty", {31'd0, fifo_empty_i}, 0);
      if (fr < 0) fr = cyc;
      lr = cyc;
      rden_cnt++;
    end
    if (m_valid_o && m_ready_i && !rst_i) begin
      if (fv < 0) fv = cyc;
      lv = cyc;
      beats++;
      if (exp_q.size() == 0) chk("extra_beat", {24'd0, m_data_o}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", {24'd0, m_data_o}, {24'd0, e});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_stats();
    beats = 0; rden_cnt = 0; fr = -1; lr = -1; fv = -1; lv = -1;
  endtask
  task automatic apply_reset();
    rst_i = 1'b1; en_i = 1'b0; fifo_error_i = 1'b0; m_ready_i = 1'b1;
    fq.delete();
    exp_q.delete();
    tick();
    repeat (2) begin
      @(negedge clk);
      chk("rst_rden", {31'd0, fifo_rd_en_o}, 0);
      tick();
    end
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, m_valid_o}, 0);
    chk("rst_data", {24'd0, m_data_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
`ifdef SY_FIFO_RD_STREAM_CNT_EN
    chk("rst_cnt", beat_cnt_o, 0);
`endif
    tick();
    clear_stats();
  endtask
  task automatic load(input logic [W-1:0] v, input bit expect_out);
    fq.push_back(v);
    if (expect_out) exp_q.push_back(v);
  endtask
  initial begin
    int k, left;
    vt[0] = '{8,  8'h01, 0, 0, 7};
    vt[1] = '{1,  8'hA5, 0, 0, 0};
    vt[2] = '{12, 8'h40, 4, 5, -1};
    vt[3] = '{6,  8'hC0, 2, 3, -1};
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      for (int i = 0; i < vt[t].n; i++) load(vt[t].base + W'(i), 1'b1);
      en_i = 1'b1;
      left = vt[t].stall_len;
      k = 0;
      while ((exp_q.size() != 0 || m_valid_o) && k < 300) begin
        m_ready_i = !(vt[t].stall_at != 0 && beats == vt[t].stall_at && left > 0);
        @(negedge clk);
        #1;
        if (!m_ready_i) begin
          left--;
          if (left == 0) begin
            chk("stall_rden", {31'd0, fifo_rd_en_o}, 0);
            chk("stall_valid", {31'd0, m_valid_o}, 1);
            chk("stall_buffered", rden_cnt - beats, 2);
            chk("stall_held", {24'd0, m_data_o}, {24'd0, vt[t].base + W'(vt[t].stall_at)});
          end
        end
        tick();
        k++;
      end
      m_ready_i = 1'b1;
      chk("drain_timeout", {31'd0, k < 300}, 1);
      repeat (4) tick();
      chk("beat_count", beats, vt[t].n);
      chk("rden_count", rden_cnt, vt[t].n);
      chk("latency", fv - fr, 2);
      chk("valid_span", lv - fv, vt[t].n - 1 + vt[t].stall_len);
      if (vt[t].rd_span >= 0) chk("rden_span", lr - fr, vt[t].rd_span);
      chk("scoreboard_empty", exp_q.size(), 0);
`ifdef SY_FIFO_RD_STREAM_CNT_EN
      chk("beat_cnt", beat_cnt_o, vt[t].n);
`endif
    end
    // error while one read is in flight
    apply_reset();
    load(8'h5A, 1'b1);
    en_i = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fifo_rd_en_o && k < 50);
    chk("err_rd_seen", {31'd0, fifo_rd_en_o}, 1);
    tick();
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    load(8'h01, 1'b0);
    load(8'h02, 1'b0);
    load(8'h03, 1'b0);
    repeat (10) tick();
    chk("err_sticky", {31'd0, err_o}, 1);
    chk("err_rden_count", rden_cnt, 1);
    chk("err_inflight_beat", beats, 1);
    chk("err_scoreboard", exp_q.size(), 0);
    // reset with two beats buffered
    apply_reset();
    for (int i = 0; i < 6; i++) load(8'h11 + W'(i), 1'b0);
    en_i = 1'b1;
    m_ready_i = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("mid_valid", {31'd0, m_valid_o}, 1);
    chk("mid_rden_count", rden_cnt, 2);
    chk("mid_rden", {31'd0, fifo_rd_en_o}, 0);
    chk("mid_head", {24'd0, m_data_o}, 32'h11);
    tick();
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, m_valid_o}, 0);
    chk("mid_rst_data", {24'd0, m_data_o}, 0);
`ifdef SY_FIFO_RD_STREAM_CNT_EN
    chk("mid_rst_cnt", beat_cnt_o, 0);
`endif
    apply_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
